// File: rtl/k053251_reg_sequencer.sv
// Shadow register file and VBLANK-gated write sequencer for the k053251 priority mixer.
// Dirty shadow entries are replayed lowest-index-first over the nCS/ADDR/DIN bus.
module k053251_reg_sequencer #(
  parameter int unsigned T_SETUP = 1,
  parameter int unsigned T_LOW   = 2,
  parameter int unsigned T_HOLD  = 1
) (
  input  logic       CLK,
  input  logic       RESET,
  input  logic       WR_REQ,
  input  logic [3:0] WR_ADDR,
  input  logic [5:0] WR_DATA,
  input  logic       COMMIT,
  input  logic       VBLANK,
  output logic       MIX_NCS,
  output logic [3:0] MIX_ADDR,
  output logic [5:0] MIX_DIN,
  output logic       BUSY,
  output logic       DONE
);

  localparam int unsigned T_MAX1 = (T_SETUP > T_LOW) ? T_SETUP : T_LOW;
  localparam int unsigned T_MAX  = (T_MAX1 > T_HOLD) ? T_MAX1 : T_HOLD;
  localparam int unsigned CW     = (T_MAX > 1) ? $clog2(T_MAX) : 1;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_SCAN   = 3'd1,
    ST_SETUP  = 3'd2,
    ST_STROBE = 3'd3,
    ST_HOLD   = 3'd4
  } state_t;

  state_t        state_r, state_s;
  logic [CW-1:0] cnt_r, cnt_s;
  logic [5:0]    shadow_r [13];
  logic [12:0]   dirty_r;
  logic          armed_r;
  logic          vb_q_r, vb_q2_r;
  logic [3:0]    idx_r;
  logic          pend_r;
  logic          mix_ncs_r, busy_r, done_r;
  logic [3:0]    mix_addr_r;
  logic [5:0]    mix_din_r;

  logic          any_dirty_s;
  logic [3:0]    low_idx_s;
  logic          wr_hit_s, wr_cur_s;
  logic          latch_s, done_s, hold_entry_s;

  assign wr_hit_s = WR_REQ && (WR_ADDR <= 4'd12);
  assign wr_cur_s = wr_hit_s && (WR_ADDR == idx_r);

  // Lowest-index dirty entry picker
  always_comb begin
    any_dirty_s = |dirty_r;
    low_idx_s   = 4'd0;
    for (int i = 12; i >= 0; i--) begin
      if (dirty_r[i]) low_idx_s = 4'(i);
      else            low_idx_s = low_idx_s;
    end
  end

  // Next-state and phase-counter logic
  always_comb begin
    state_s      = state_r;
    cnt_s        = (cnt_r != '0) ? cnt_r - CW'(1) : cnt_r;
    latch_s      = 1'b0;
    done_s       = 1'b0;
    hold_entry_s = 1'b0;
    case (state_r)
      ST_IDLE: begin
        if (vb_q_r && !vb_q2_r && armed_r) state_s = ST_SCAN;
        else                               state_s = ST_IDLE;
      end
      ST_SCAN: begin
        if (!vb_q_r) begin
          state_s = ST_IDLE;
        end else if (any_dirty_s) begin
          state_s = ST_SETUP;
          latch_s = 1'b1;
          cnt_s   = CW'(T_SETUP - 1);
        end else begin
          state_s = ST_IDLE;
          done_s  = 1'b1;
        end
      end
      ST_SETUP: begin
        if (cnt_r == '0) begin
          state_s = ST_STROBE;
          cnt_s   = CW'(T_LOW - 1);
        end else begin
          state_s = ST_SETUP;
        end
      end
      ST_STROBE: begin
        if (cnt_r == '0) begin
          state_s      = ST_HOLD;
          cnt_s        = CW'(T_HOLD - 1);
          hold_entry_s = 1'b1;
        end else begin
          state_s = ST_STROBE;
        end
      end
      ST_HOLD: begin
        if (cnt_r == '0) state_s = ST_SCAN;
        else             state_s = ST_HOLD;
      end
      default: state_s = ST_IDLE;
    endcase
  end

  // State, counter, VBLANK sync and registered bus outputs
  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      state_r    <= ST_IDLE;
      cnt_r      <= '0;
      vb_q_r     <= 1'b0;
      vb_q2_r    <= 1'b0;
      idx_r      <= 4'd0;
      mix_ncs_r  <= 1'b1;
      busy_r     <= 1'b0;
      done_r     <= 1'b0;
      mix_addr_r <= 4'd0;
      mix_din_r  <= 6'd0;
    end else begin
      state_r   <= state_s;
      cnt_r     <= cnt_s;
      vb_q_r    <= VBLANK;
      vb_q2_r   <= vb_q_r;
      mix_ncs_r <= (state_s != ST_STROBE);
      busy_r    <= (state_s != ST_IDLE);
      done_r    <= done_s;
      if (latch_s) begin
        idx_r      <= low_idx_s;
        mix_addr_r <= low_idx_s;
        mix_din_r  <= shadow_r[low_idx_s];
      end
    end
  end

  // A write to the in-flight entry after its value was latched must keep it dirty
  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      pend_r <= 1'b0;
    end else if (latch_s) begin
      pend_r <= wr_hit_s && (WR_ADDR == low_idx_s);
    end else if (wr_cur_s && (state_r == ST_SETUP || state_r == ST_STROBE)) begin
      pend_r <= 1'b1;
    end else begin
      pend_r <= pend_r;
    end
  end

  // Shadow storage and dirty tracking; a CPU write overrides the HOLD-entry clear
  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      for (int i = 0; i < 13; i++) shadow_r[i] <= 6'd0;
      dirty_r <= '1;
    end else begin
      if (hold_entry_s && !pend_r) dirty_r[idx_r] <= 1'b0;
      if (wr_hit_s) begin
        dirty_r[WR_ADDR]  <= 1'b1;
        shadow_r[WR_ADDR] <= (WR_ADDR == 4'd12) ? {3'b000, WR_DATA[2:0]} : WR_DATA;
      end
    end
  end

  // Replay arming; COMMIT wins over the DONE clear
  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET)       armed_r <= 1'b1;
    else if (COMMIT) armed_r <= 1'b1;
    else if (done_s) armed_r <= 1'b0;
    else             armed_r <= armed_r;
  end

  assign MIX_NCS  = mix_ncs_r;
  assign MIX_ADDR = mix_addr_r;
  assign MIX_DIN  = mix_din_r;
  assign BUSY     = busy_r;
  assign DONE     = done_r;

endmodule
